// File: rtl/lc3b_imm_pkg.sv
// Shared widths, field-select encodings and the result payload type
// for the LC-3b immediate-extraction arbiter.
package lc3b_imm_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREQ   = 2;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] SEL_IMM5  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_OFF6  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_PC9   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_PC11  = 3'd3;
    localparam logic [SEL_W-1:0] SEL_TRAP8 = 3'd4;
    localparam logic [SEL_W-1:0] SEL_AMT4  = 3'd5;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              id;
        logic              err;
    } imm_rsp_t;

endpackage

// File: rtl/imm_field_ext.sv
// Combinational LC-3b immediate field extraction, sign/zero extension
// and optional left shift by one.
module imm_field_ext
    import lc3b_imm_pkg::*;
(
    input  logic [DATA_W-1:0] ir,
    input  logic [SEL_W-1:0]  sel,
    input  logic              lshf,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [DATA_W-1:0] ext;

    always_comb begin
        ext = '0;
        err = 1'b0;
        case (sel)
            SEL_IMM5:  ext = {{11{ir[4]}}, ir[4:0]};
            SEL_OFF6:  ext = {{10{ir[5]}}, ir[5:0]};
            SEL_PC9:   ext = {{7{ir[8]}}, ir[8:0]};
            SEL_PC11:  ext = {{5{ir[10]}}, ir[10:0]};
            SEL_TRAP8: ext = {8'h00, ir[7:0]};
            SEL_AMT4:  ext = {12'h000, ir[3:0]};
            default:   err = 1'b1;
        endcase
        // The shift drops the top extended bit; reserved selects stay zero.
        data = lshf ? {ext[DATA_W-2:0], 1'b0} : ext;
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate-extension datapath between
// decode (port 0) and address generation (port 1), with a registered result.
module imm_ext_arbiter
    import lc3b_imm_pkg::*;
(
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [DATA_W-1:0] req_ir0,
    input  logic [DATA_W-1:0] req_ir1,
    input  logic [SEL_W-1:0]  req_sel0,
    input  logic [SEL_W-1:0]  req_sel1,
    input  logic [NREQ-1:0]   req_lshf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err
);

    imm_rsp_t          rsp_q;
    logic              rr_ptr;
    logic              can_load;
    logic              any_req;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] mux_ir;
    logic [SEL_W-1:0]  mux_sel;
    logic              mux_lshf;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;

    // Grant, handshake and operand mux; nothing is accepted while in reset.
    always_comb begin
        can_load  = !rsp_q.valid || rsp_ready;
        any_req   = |req_valid;
        grant     = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
        req_ready = '0;
        if (reset_n && can_load && any_req) begin
            req_ready[grant] = 1'b1;
        end
        accept   = |(req_valid & req_ready);
        mux_ir   = grant ? req_ir1  : req_ir0;
        mux_sel  = grant ? req_sel1 : req_sel0;
        mux_lshf = req_lshf[grant];
    end

    imm_field_ext u_ext (
        .ir   (mux_ir),
        .sel  (mux_sel),
        .lshf (mux_lshf),
        .data (ext_data),
        .err  (ext_err)
    );

    // Single output stage; payload is held while the consumer stalls.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            rsp_q  <= '0;
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rsp_q.valid <= 1'b1;
            rsp_q.data  <= ext_data;
            rsp_q.id    <= grant;
            rsp_q.err   <= ext_err;
            rr_ptr      <= ~grant;
        end else if (rsp_ready) begin
            rsp_q.valid <= 1'b0;
        end
    end

    assign rsp_valid = rsp_q.valid;
    assign rsp_data  = rsp_q.data;
    assign rsp_id    = rsp_q.id;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed self-checking bench for imm_ext_arbiter.
module tb_imm_ext_arbiter;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_ir0, req_ir1;
    logic [2:0]  req_sel0, req_sel1;
    logic [1:0]  req_lshf;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    always #10 clk_50 = ~clk_50;

    imm_ext_arbiter dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ir0   (req_ir0),
        .req_ir1   (req_ir1),
        .req_sel0  (req_sel0),
        .req_sel1  (req_sel1),
        .req_lshf  (req_lshf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b11;
        req_ir0   = 16'h0000;
        req_ir1   = 16'h0000;
        req_sel0  = 3'd0;
        req_sel1  = 3'd0;
        req_lshf  = 2'b00;
        rsp_ready = 1'b0;

        // Reset with both ports requesting
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_req_ready", 16'(req_ready), 16'h0000);
            chk("rst_rsp_valid", 16'(rsp_valid), 16'h0000);
            chk("rst_rsp_data",  rsp_data,       16'h0000);
        end

        reset_n   = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();

        // Port 0 imm5
        req_ir0 = 16'h001F; req_sel0 = 3'd0; req_lshf = 2'b00; req_valid = 2'b01;
        settle();
        chk("p0_ready", 16'(req_ready), 16'h0001);
        step();
        req_valid = 2'b00;
        chk("p0_valid", 16'(rsp_valid), 16'h0001);
        chk("p0_data",  rsp_data,       16'hFFFF);
        chk("p0_id",    16'(rsp_id),    16'h0000);
        chk("p0_err",   16'(rsp_err),   16'h0000);

        // Port 1 PCoff9 with shift, then trapvect8
        req_ir1 = 16'h01FF; req_sel1 = 3'd2; req_lshf = 2'b10; req_valid = 2'b10;
        settle();
        chk("p1_ready", 16'(req_ready), 16'h0002);
        step();
        chk("p1_pc9_data", rsp_data,    16'hFFFE);
        chk("p1_pc9_id",   16'(rsp_id), 16'h0001);
        req_ir1 = 16'h00FF; req_sel1 = 3'd4; req_lshf = 2'b00;
        step();
        req_valid = 2'b00;
        chk("p1_trap_data", rsp_data,    16'h00FF);
        chk("p1_trap_id",   16'(rsp_id), 16'h0001);
        step();
        chk("drain_valid", 16'(rsp_valid), 16'h0000);

        // Both valid, alternating grants starting at port 0
        req_ir0 = 16'h0010; req_sel0 = 3'd0;
        req_ir1 = 16'h0005; req_sel1 = 3'd5; req_lshf = 2'b10;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_ready", 16'(req_ready), (i % 2 == 0) ? 16'h0001 : 16'h0002);
            if (i == 3) rsp_ready = 1'b1;
            step();
            chk("rr_valid", 16'(rsp_valid), 16'h0001);
            chk("rr_id",    16'(rsp_id),    (i % 2 == 0) ? 16'h0000 : 16'h0001);
            chk("rr_data",  rsp_data,       (i % 2 == 0) ? 16'hFFF0 : 16'h000A);
        end

        // Stall: held result from port 1, no accepts
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_ready", 16'(req_ready), 16'h0000);
            step();
            chk("stall_valid", 16'(rsp_valid), 16'h0001);
            chk("stall_id",    16'(rsp_id),    16'h0001);
            chk("stall_data",  rsp_data,       16'h000A);
        end
        rsp_ready = 1'b1;
        settle();
        chk("release_ready", 16'(req_ready), 16'h0001);
        step();
        req_valid = 2'b00;
        chk("release_id",   16'(rsp_id), 16'h0000);
        chk("release_data", rsp_data,    16'hFFF0);
        step();
        chk("release_drain", 16'(rsp_valid), 16'h0000);

        // Reserved select with shift, then PCoff11
        req_ir0 = 16'hFFFF; req_sel0 = 3'd7; req_lshf = 2'b01; req_valid = 2'b01;
        step();
        chk("rsv_data", rsp_data,     16'h0000);
        chk("rsv_err",  16'(rsp_err), 16'h0001);
        req_ir0 = 16'h0400; req_sel0 = 3'd3; req_lshf = 2'b00;
        step();
        req_valid = 2'b00;
        chk("pc11_data", rsp_data,     16'hFC00);
        chk("pc11_err",  16'(rsp_err), 16'h0000);
        chk("pc11_id",   16'(rsp_id),  16'h0000);

        // Reset while a result is held discards it
        rsp_ready = 1'b0;
        step();
        chk("hold_before_rst", 16'(rsp_valid), 16'h0001);
        reset_n = 1'b0;
        step();
        chk("midrst_valid", 16'(rsp_valid), 16'h0000);
        chk("midrst_data",  rsp_data,       16'h0000);
        reset_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
